// File: rtl/hog_stream_pkg.sv
// rtl/hog_stream_pkg.sv - shared stream geometry for the window data path
package hog_stream_pkg;

    localparam int BUS_WIDTH    = 128;
    localparam int WINDOW_WIDTH = 1152;
    localparam int PKT_BEATS    = WINDOW_WIDTH / BUS_WIDTH;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    localparam int BEAT_WIDTH = clog2(PKT_BEATS);

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port array, registered write, combinational read
module sdp_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // No reset: contents are only meaningful between the pointers.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pkt_store_fwd_fifo.sv
// rtl/pkt_store_fwd_fifo.sv - store-and-forward window FIFO, presents only complete windows
module pkt_store_fwd_fifo #(
    parameter int BUS_WIDTH  = hog_stream_pkg::BUS_WIDTH,
    parameter int PKT_BEATS  = hog_stream_pkg::PKT_BEATS,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BUS_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BUS_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [ADDR_WIDTH:0]   level
);

    import hog_stream_pkg::*;

    localparam int                  BEAT_W    = clog2(PKT_BEATS);
    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(PKT_BEATS - 1);
    localparam logic [ADDR_WIDTH:0] WRAP_BIT  = {1'b1, {ADDR_WIDTH{1'b0}}};

    generate
        if ((2 ** ADDR_WIDTH) < PKT_BEATS) begin : g_depth_check
            $error("pkt_store_fwd_fifo: storage shallower than one packet");
        end
    endgenerate

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [BEAT_W-1:0]   r_in_beat;
    logic [BEAT_W-1:0]   r_out_beat;
    logic [ADDR_WIDTH:0] r_pkt_count;

    logic w_full;
    logic w_wr;
    logic w_rd;
    logic w_pkt_done;
    logic w_pkt_drain;

    assign w_full      = ((r_wr_ptr ^ r_rd_ptr) == WRAP_BIT);
    assign in_ready    = !w_full;
    assign out_valid   = (r_pkt_count != '0);
    assign out_last    = out_valid && (r_out_beat == LAST_BEAT);
    assign pkt_count   = r_pkt_count;
    assign level       = r_wr_ptr - r_rd_ptr;

    assign w_wr        = in_valid && in_ready;
    assign w_rd        = out_valid && out_ready;
    assign w_pkt_done  = w_wr && (r_in_beat == LAST_BEAT);
    assign w_pkt_drain = w_rd && (r_out_beat == LAST_BEAT);

    sdp_ram #(
        .DATA_WIDTH (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_in_beat <= '0;
        end else if (w_wr) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_in_beat <= (r_in_beat == LAST_BEAT) ? '0 : r_in_beat + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_out_beat <= '0;
        end else if (w_rd) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_out_beat <= (r_out_beat == LAST_BEAT) ? '0 : r_out_beat + 1'b1;
        end
    end

    // A window completing and another draining in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= '0;
        end else begin
            case ({w_pkt_done, w_pkt_drain})
                2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
                2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_store_fwd_fifo.sv
// tb/tb_pkt_store_fwd_fifo.sv - directed and scoreboarded bench for pkt_store_fwd_fifo
module tb_pkt_store_fwd_fifo;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [5:0]   pkt_count;
    logic [5:0]   level;

    int n_cmp;
    int n_err;

    pkt_store_fwd_fifo #(
        .BUS_WIDTH  (128),
        .PKT_BEATS  (9),
        .ADDR_WIDTH (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .pkt_count (pkt_count),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with a complete window at the head; consumes n beats.
    task automatic drain(input string tag, input int first, input int n);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_data"}, out_data, 128'(first + k));
            check({tag, "_last"}, out_last, (k % 9) == 8);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] q[$];
        logic [127:0] prev_data;
        logic [127:0] exp_data;
        logic         prev_last;
        bit           prev_stall;
        int           wr_n;
        int           rd_n;
        int           cyc;

        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_level", level, 0);
        check("rst_pkt_count", pkt_count, 0);
        rst_n = 1'b1;

        // One window, consumer always ready: nothing shows until beat 9 lands.
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("t1_hold_valid", out_valid, 0);
            in_valid = 1'b1;
            in_data  = 128'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_pkt_count", pkt_count, 1);
        drain("t1", 1, 9);
        check("t1_pkt_after", pkt_count, 0);
        check("t1_valid_after", out_valid, 0);

        // Producer stalls mid-window: partial window is never exposed.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(200 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            check("t2_stall_valid", out_valid, 0);
            check("t2_stall_level", level, 8);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = 128'(209);
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_pkt_count", pkt_count, 1);
        drain("t2", 201, 9);

        // Fill to full with consumer blocked.
        for (int i = 1; i <= 32; i++) begin
            check("t3_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = 128'(100 + i);
            @(negedge clk);
        end
        in_data = 128'hDEAD;
        check("t3_full_ready", in_ready, 0);
        check("t3_full_level", level, 32);
        check("t3_full_pkts", pkt_count, 3);
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_no_overwrite_level", level, 32);
        drain("t3", 101, 27);
        check("t3_tail_valid", out_valid, 0);
        check("t3_tail_level", level, 5);
        for (int i = 133; i <= 136; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain("t3b", 128, 9);

        // Two windows back to back: completion and drain coincide at c=17.
        for (int c = 0; c < 28; c++) begin
            if (c == 9) begin
                check("t4_first_valid", out_valid, 1);
                check("t4_first_data", out_data, 301);
            end
            if (c == 17) begin
                check("t4_pre_pkts", pkt_count, 1);
                check("t4_pre_last", out_last, 1);
                check("t4_pre_data", out_data, 309);
            end
            if (c == 18) begin
                check("t4_post_pkts", pkt_count, 1);
                check("t4_post_data", out_data, 310);
                check("t4_post_last", out_last, 0);
            end
            if (c == 27) begin
                check("t4_end_pkts", pkt_count, 0);
                check("t4_end_level", level, 0);
            end
            in_valid  = (c < 18);
            in_data   = 128'(301 + c);
            out_ready = 1'b1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Random handshakes over 1000 windows against a queue model.
        wr_n       = 0;
        rd_n       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (rd_n < 9000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            check("rand_pkts", pkt_count, 128'(wr_n / 9 - rd_n / 9));
            check("rand_level", level, 128'(wr_n - rd_n));
            check("rand_valid", out_valid, (wr_n / 9 - rd_n / 9) != 0);
            if (prev_stall) begin
                check("rand_hold_data", out_data, prev_data);
                check("rand_hold_last", out_last, prev_last);
            end
            in_valid  = (wr_n < 9000) && ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                wr_n++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_underrun", 1, 0);
                end else begin
                    exp_data = q.pop_front();
                    check("rand_data", out_data, exp_data);
                end
                check("rand_last", out_last, (rd_n % 9) == 8);
                rd_n++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        check("rand_beats", rd_n, 9000);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rand_end_level", level, 0);

        // Asynchronous reset with one full and one partial window buffered.
        for (int i = 1; i <= 14; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(400 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t6_pre_pkts", pkt_count, 1);
        check("t6_pre_level", level, 14);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_last", out_last, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_pkts", pkt_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(500 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t6_clean_pkts", pkt_count, 1);
        drain("t6", 501, 9);
        check("t6_end_pkts", pkt_count, 0);
        check("t6_end_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
